enc_bin2onehot: RTL and testbench
=================================

// Module: enc_bin2onehot
//
// PURPOSE
// - Registered binary-to-one-hot encoder: converts an IN_W-bit binary code into an
//   OUT_W-bit one-hot vector, one clock of latency.
// - Code 0 is the "none" code and produces an all-zero vector.
// - Sits between control logic producing a binary index and a consumer that needs
//   per-line select/enable strobes, e.g. mux selects or bank enables.
//
// PARAMETERS
// - IN_W   4             width of the binary input code
// - OUT_W  (1<<IN_W)-1   one-hot output width; default 15. Must equal (1<<IN_W)-1.
//
// PORTS
// - clk        input   1      single clock; all state updates on rising edge
// - rst        input   1      reset, synchronous, active-high
// - in         input   IN_W   binary code to encode
// - in_valid   input   1      qualifies in; sampled on the same rising edge as in
// - out        output  OUT_W  registered one-hot result
// - out_valid  output  1      registered; high for the cycle after an accepted input
//
// BEHAVIOUR
// - Reset:
//   - rst=1 at a rising edge forces out=0 and out_valid=0.
//   - Reset has priority over in_valid.
//   - Reset asserted mid-stream discards the pending result; the next edge shows zeros.
// - Encoding, for an edge with rst=0 and in_valid=1:
//   - in==0: out <= 0.
//   - in==k, 1<=k<=OUT_W: out <= 1<<(k-1), i.e. exactly bit k-1 set.
//   - in==15 (default widths): out = 15'h4000, the MSB.
// - Latency: one cycle. Result visible after the edge that samples in/in_valid.
//   out_valid <= in_valid on every non-reset edge.
// - in_valid=0 (no reset): out holds its previous value, out_valid <= 0.
//   See CONFIGURATION for the alternative.
// - Output invariant: out is always either all-zero or has exactly one bit set.
//   $onehot0(out) holds every cycle.
// - Back-to-back inputs:
//   - Accepted every cycle with no bubbles.
//   - A new valid input overwrites out regardless of the previous value.
//   - No backpressure.
// - Elaboration:
//   - A generate-time check must fail elaboration if OUT_W != (1<<IN_W)-1.
//   - Encoding is a combinational decode loop over OUT_W bits, compared against
//     in-1, feeding the output register.
//
// CONFIGURATION
// - Macro ENC_BIN2ONEHOT_CLEAR_ON_IDLE_EN:
//   - Defined: out <= 0 on any non-reset edge where in_valid=0, so out is nonzero
//     only in cycles where out_valid=1.
//   - Undefined (default): out holds its last value when in_valid=0.
// - Reset and encoding behaviour are otherwise identical in both builds.
//
// TESTING
// - Reset: hold rst=1 for 2 cycles with in=4'hF, in_valid=1 -> out=15'h0000 and
//   out_valid=0 on both edges.
// - Sweep: in=0..15 with in_valid=1 every cycle -> one cycle later out=0 for in=0,
//   then out=1<<(in-1) (in=1 -> 15'h0001, in=8 -> 15'h0080, in=15 -> 15'h4000),
//   with out_valid=1 throughout.
// - Idle hold: in=5 valid (out=15'h0010), then in_valid=0 with in=9 ->
//   - default build: out stays 15'h0010 and out_valid=0;
//   - ENC_BIN2ONEHOT_CLEAR_ON_IDLE_EN build: out becomes 15'h0000.
// - Mid-stream reset: in=3 valid, then rst=1 for one cycle with in=7 valid ->
//   out=0 and out_valid=0; after rst drops, in=7 yields out=15'h0040.
// - Invariant/random: 1000 random cycles of in, in_valid and rare rst -> $onehot0(out)
//   every cycle, and out matches a reference model delayed by one cycle.

Source files
------------

// File: rtl/enc_bin2onehot_if.sv
// Binary code / one-hot result bundle for enc_bin2onehot.
// The master drives the binary code; the slave (the encoder) returns the one-hot vector.
interface enc_bin2onehot_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = (1 << IN_W) - 1
);
    logic [IN_W-1:0]  in;
    logic             in_valid;
    logic [OUT_W-1:0] out;
    logic             out_valid;

    modport master (
        output in,
        output in_valid,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in,
        input  in_valid,
        output out,
        output out_valid
    );
endinterface

// File: rtl/enc_bin2onehot.sv
// Registered binary-to-one-hot encoder: code 0 -> all zeros, code k -> bit k-1 set, one cycle latency.
// Optional build macro ENC_BIN2ONEHOT_CLEAR_ON_IDLE_EN: clear out on idle cycles instead of holding it.
module enc_bin2onehot #(
    parameter int IN_W  = 4,
    parameter int OUT_W = (1 << IN_W) - 1
) (
    input logic            clk,
    input logic            rst,
    enc_bin2onehot_if.slave bus
);
    // Every nonzero code needs its own output line, and no line may be left without a code.
    if (OUT_W != (1 << IN_W) - 1) begin : g_width_check
        $error("enc_bin2onehot: OUT_W must equal (1<<IN_W)-1");
    end

    logic [IN_W-1:0]  code_m1_p0;
    logic [OUT_W-1:0] dec_p0;
    logic [OUT_W-1:0] out_p1;
    logic             vld_p1;

    // Stage p0: combinational decode. Code 0 wraps to all ones, which is one past the
    // highest line index, so it matches nothing and yields the all-zero "none" vector.
    assign code_m1_p0 = bus.in - IN_W'(1);

    always_comb begin
        dec_p0 = '0;
        for (int i = 0; i < OUT_W; i++) begin
            dec_p0[i] = (code_m1_p0 == IN_W'(i));
        end
    end

    // Stage p1: output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
`ifdef ENC_BIN2ONEHOT_CLEAR_ON_IDLE_EN
            out_p1 <= bus.in_valid ? dec_p0 : '0;
`else
            if (bus.in_valid) begin
                out_p1 <= dec_p0;
            end
`endif
        end
    end

    assign bus.out       = out_p1;
    assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_enc_bin2onehot.sv
// Bench for enc_bin2onehot: directed vector table, then random cycles against a reference model.
module tb_enc_bin2onehot;
    localparam int IN_W  = 4;
    localparam int OUT_W = 15;

    typedef struct {
        logic             r;
        logic [IN_W-1:0]  code;
        logic             v;
        logic [OUT_W-1:0] exp_out;
        logic             exp_vld;
        string            name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    logic [OUT_W-1:0] m_out;
    logic             m_vld;

    enc_bin2onehot_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    enc_bin2onehot #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: one-hot value is 2^(code-1), code 0 means nothing selected.
    function automatic logic [OUT_W-1:0] ref_onehot(input int code);
        int val;
        val = (code == 0) ? 0 : (2 ** (code - 1));
        return OUT_W'(val);
    endfunction

    // Drive one cycle, advance the reference model across the edge, then sample.
    task automatic step(input logic r, input logic [IN_W-1:0] code, input logic v);
        @(negedge clk);
        rst          = r;
        bus.in       = code;
        bus.in_valid = v;
        @(posedge clk);
        if (r) begin
            m_out = '0;
            m_vld = 1'b0;
        end else begin
            m_vld = v;
            if (v) begin
                m_out = ref_onehot(int'(code));
            end else begin
`ifdef ENC_BIN2ONEHOT_CLEAR_ON_IDLE_EN
                m_out = '0;
`endif
            end
        end
        #1;
    endtask

    vec_t vecs[$];
    logic [OUT_W-1:0] idle_exp;

    initial begin
        rst          = 1'b1;
        bus.in       = '0;
        bus.in_valid = 1'b0;
        m_out        = '0;
        m_vld        = 1'b0;

`ifdef ENC_BIN2ONEHOT_CLEAR_ON_IDLE_EN
        idle_exp = 15'h0000;
`else
        idle_exp = 15'h0010;
`endif
        vecs.push_back('{1'b1, 4'hF, 1'b1, 15'h0000, 1'b0, "reset0"});
        vecs.push_back('{1'b1, 4'hF, 1'b1, 15'h0000, 1'b0, "reset1"});
        for (int k = 0; k < 16; k++) begin
            vecs.push_back('{1'b0, 4'(k), 1'b1,
                             (k == 0) ? 15'h0000 : (15'h0001 << (k - 1)), 1'b1, $sformatf("sweep%0d", k)});
        end
        vecs.push_back('{1'b0, 4'd5, 1'b1, 15'h0010, 1'b1, "idle_load"});
        vecs.push_back('{1'b0, 4'd9, 1'b0, idle_exp, 1'b0, "idle_hold"});
        vecs.push_back('{1'b0, 4'd3, 1'b1, 15'h0004, 1'b1, "mid_pre"});
        vecs.push_back('{1'b1, 4'd7, 1'b1, 15'h0000, 1'b0, "mid_rst"});
        vecs.push_back('{1'b0, 4'd7, 1'b1, 15'h0040, 1'b1, "mid_post"});
        vecs.push_back('{1'b0, 4'd15, 1'b1, 15'h4000, 1'b1, "msb"});
        vecs.push_back('{1'b0, 4'd1, 1'b1, 15'h0001, 1'b1, "b2b_overwrite"});
        vecs.push_back('{1'b0, 4'd0, 1'b1, 15'h0000, 1'b1, "none_code"});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].code, vecs[i].v);
            check({vecs[i].name, "_out"}, bus.out, vecs[i].exp_out);
            check({vecs[i].name, "_vld"}, OUT_W'(bus.out_valid), OUT_W'(vecs[i].exp_vld));
        end

        // Hand-written check of the spot values in the sweep (in=8 -> bit 7).
        step(1'b0, 4'd8, 1'b1);
        check("sweep_in8", bus.out, 15'h0080);

        for (int c = 0; c < 1000; c++) begin
            logic r, v;
            logic [IN_W-1:0] code;
            r    = ($urandom_range(0, 31) == 0);
            v    = ($urandom_range(0, 3) != 0);
            code = IN_W'($urandom);
            step(r, code, v);
            check("rand_out", bus.out, m_out);
            check("rand_vld", OUT_W'(bus.out_valid), OUT_W'(m_vld));
            check("rand_onehot0", OUT_W'($onehot0(bus.out)), OUT_W'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
